spi_buf_sched: RTL and testbench
================================

Name: spi_buf_sched

Overview:
- Port-B sequencer for the shared 256x32 Wishbone/SPI message buffer.
- Scans buffer slots round-robin and picks up messages posted from the Wishbone side: busy=1, ready=0.
- Runs each message as one transaction on the SPI master request interface.
- Writes the result back into the slot with ready set, so the Wishbone side can collect it and free the slot.

Parameters:
- DEPTH, 256, number of buffer slots scanned (slots 0..DEPTH-1).
- AW, 8, buffer address width.
- TIMEOUT, 1024, max clk cycles to wait for spi_done before aborting a transaction.
- TW, 11, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock; the buffer's port B clock (clkb) is tied to this net.
- rst_n  in  1  asynchronous active-low reset.
- sched_en  in  1  scheduler enable.
- enb  out  1  buffer port-B enable.
- web  out  1  buffer port-B write enable.
- addrb  out  AW  buffer port-B address.
- dib  out  32  buffer port-B write data.
- dob  in  32  buffer port-B read data.
- spi_req  out  1  SPI transaction request, level.
- spi_rnw  out  1  1=SPI read, 0=SPI write.
- spi_addr  out  7  SPI register address.
- spi_wdata  out  8  SPI write data.
- spi_done  in  1  one-cycle completion pulse from SPI master.
- spi_rdata  in  8  SPI read data, valid with spi_done.
- sched_busy  out  1  high in every state except IDLE.
- msg_cnt  out  16  messages completed OK; wraps at 0xFFFF->0.
- err_cnt  out  8  messages aborted by timeout; saturates at 0xFF.

Behaviour:
- Message word layout:
  - [31] ready
  - [30] busy
  - [29] R/nW
  - [28] error
  - [27:15] reserved; written back unchanged
  - [14:8] addr
  - [7:0] data
- Reset: all outputs 0. State=IDLE. Slot pointer=0. Timeout counter=0.
- Port timing: buffer port B samples on the falling edge of clk. All scheduler outputs are registered on the rising edge, from state.
- Read latency: a read driven in state RD gives dob valid at the next rising edge, sampled in CHK.
- States:
  - IDLE: all port/SPI outputs 0. When sched_en=1, go to RD.
  - RD: enb=1, web=0, addrb=ptr. Go to CHK.
  - CHK: enb=0; evaluate dob.
    - If dob[30]=1 and dob[31]=0: latch word and go to REQ.
    - Otherwise: ptr advances (DEPTH-1 wraps to 0); go to RD if sched_en=1, else IDLE.
  - REQ: spi_req=1.
    - spi_rnw=word[29], spi_addr=word[14:8], spi_wdata=word[7:0].
    - These fields are held stable until the request drops.
    - Timeout counter clears on entry. Go to WAIT.
  - WAIT: spi_req stays 1; counter increments each cycle.
    - spi_done=1: spi_req=0 next cycle. If word[29]=1, replace data byte with spi_rdata. Error bit=0. msg_cnt+1. Go to WB.
    - Counter reaches TIMEOUT without spi_done: spi_req=0. Data unchanged. Error bit=1. err_cnt+1 (saturating). Go to WB.
  - WB: enb=1, web=1, addrb=ptr, dib={1'b1, 1'b1, word[29], errbit, word[27:8], databyte}.
    - Ptr advances. Go to RD if sched_en=1, else IDLE.
- Latency, idle slot with sched_en held: one slot scanned per 2 cycles.
- Latency, served message: SPI round trip + 4 cycles (RD, CHK, REQ, WB).
- Scan order: strict ascending with wrap. A slot found busy-not-ready is served before the pointer moves; no skipping or reordering.
- sched_en deasserted mid-message: the in-flight message completes through WB, then IDLE. The pointer is kept, and scanning resumes there when sched_en returns.
- Slots with busy=1, ready=1 (result not yet collected) are skipped without a write.
- The scheduler never writes a slot it did not read as busy-not-ready in the same pass.
- spi_done outside WAIT: ignored.
- spi_done in the same cycle the counter reaches TIMEOUT: spi_done wins; normal completion.
- Reset mid-transaction: spi_req drops immediately (asynchronous). The slot is left busy-not-ready and is re-served after the rescan from slot 0.
- Wishbone-side contention: safe by protocol.
  - The Wishbone side cannot write a busy slot.
  - It clears busy only after ready=1.
  - The scheduler needs no port-A interlock.

Test Plan:
- Reset, then sched_en=1 with all slots 0 -> RD/CHK alternate; addrb sweeps 0..255 and wraps to 0; web never 1; spi_req never 1.
- Slot 5 = 0x4000_1234 (write, addr 0x12, data 0x34) -> spi_req=1, spi_rnw=0, spi_addr=0x12, spi_wdata=0x34. After spi_done: web=1, addrb=5, dib=0xC000_1234; msg_cnt=1.
- Slot 9 = 0x6000_2A00 (read, addr 0x2A); SPI returns spi_rdata=0xA5 -> dib=0xE000_2AA5 at addrb=9.
- Slot 3 busy-not-ready; spi_done withheld -> spi_req drops after TIMEOUT cycles; dib=0xD000_xxxx (error set, data unchanged); err_cnt=1. Repeat 300 times -> err_cnt stays 0xFF.
- Slots 2 and 200 pending; sched_en dropped during slot 2's WAIT -> slot 2 written back, then IDLE. Re-enable -> slot 200 served next.
- rst_n pulsed low during WAIT on slot 7 -> spi_req=0 immediately. After release, slot 7 served again and written back with ready=1.

Source files
------------

// File: rtl/spi_buf_sched_if.sv
// Port-B buffer bus and SPI master request bus seen by the message scheduler.
// master = scheduler side, slave = buffer + SPI master side.
interface spi_buf_sched_if #(
    parameter int AW = 8
);
    logic          enb;
    logic          web;
    logic [AW-1:0] addrb;
    logic [31:0]   dib;
    logic [31:0]   dob;

    logic          spi_req;
    logic          spi_rnw;
    logic [6:0]    spi_addr;
    logic [7:0]    spi_wdata;
    logic          spi_done;
    logic [7:0]    spi_rdata;

    modport master (
        output enb, web, addrb, dib,
        output spi_req, spi_rnw, spi_addr, spi_wdata,
        input  dob, spi_done, spi_rdata
    );

    modport slave (
        input  enb, web, addrb, dib,
        input  spi_req, spi_rnw, spi_addr, spi_wdata,
        output dob, spi_done, spi_rdata
    );
endinterface

// File: rtl/spi_buf_sched.sv
// Port-B sequencer for the shared Wishbone/SPI message buffer: scans slots round-robin,
// runs each busy-not-ready message as one SPI transaction and writes the result back.
module spi_buf_sched #(
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sched_en,
    spi_buf_sched_if.master bus,
    output logic            sched_busy,
    output logic [15:0]     msg_cnt,
    output logic [7:0]      err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD   = 3'd1,
        S_CHK  = 3'd2,
        S_REQ  = 3'd3,
        S_WAIT = 3'd4,
        S_WB   = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [29:0]   word_q, word_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [15:0]   msg_cnt_q, msg_cnt_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          enb_q, enb_d;
    logic          web_q, web_d;
    logic [AW-1:0] addrb_q, addrb_d;
    logic [31:0]   dib_q, dib_d;
    logic          spi_req_q, spi_req_d;
    logic          spi_rnw_q, spi_rnw_d;
    logic [6:0]    spi_addr_q, spi_addr_d;
    logic [7:0]    spi_wdata_q, spi_wdata_d;
    logic          busy_q, busy_d;

    logic [AW-1:0] ptr_next;
    logic          tmo_last;
    logic          slot_pending;

    assign ptr_next     = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    assign tmo_last     = (tmo_q == TW'(TIMEOUT - 1));
    assign slot_pending = bus.dob[30] && !bus.dob[31];

    // Only [29:0] of the message is kept: ready/busy are always rewritten as 1/1 on write-back,
    // and bit 28 doubles as the live error flag for the transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            word_q      <= '0;
            tmo_q       <= '0;
            msg_cnt_q   <= '0;
            err_cnt_q   <= '0;
            enb_q       <= 1'b0;
            web_q       <= 1'b0;
            addrb_q     <= '0;
            dib_q       <= '0;
            spi_req_q   <= 1'b0;
            spi_rnw_q   <= 1'b0;
            spi_addr_q  <= '0;
            spi_wdata_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            word_q      <= word_d;
            tmo_q       <= tmo_d;
            msg_cnt_q   <= msg_cnt_d;
            err_cnt_q   <= err_cnt_d;
            enb_q       <= enb_d;
            web_q       <= web_d;
            addrb_q     <= addrb_d;
            dib_q       <= dib_d;
            spi_req_q   <= spi_req_d;
            spi_rnw_q   <= spi_rnw_d;
            spi_addr_q  <= spi_addr_d;
            spi_wdata_q <= spi_wdata_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
        state_d   = state_q;
        ptr_d     = ptr_q;
        word_d    = word_q;
        tmo_d     = tmo_q;
        msg_cnt_d = msg_cnt_q;
        err_cnt_d = err_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (sched_en) state_d = S_RD;
            end
            S_RD: begin
                state_d = S_CHK;
            end
            S_CHK: begin
                if (slot_pending) begin
                    word_d  = bus.dob[29:0];
                    state_d = S_REQ;
                end else begin
                    ptr_d   = ptr_next;
                    state_d = sched_en ? S_RD : S_IDLE;
                end
            end
            S_REQ: begin
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tmo_d = tmo_q + 1'b1;
                // A completion in the final counted cycle still counts as success.
                if (bus.spi_done) begin
                    if (word_q[29]) word_d[7:0] = bus.spi_rdata;
                    word_d[28] = 1'b0;
                    msg_cnt_d  = msg_cnt_q + 16'd1;
                    state_d    = S_WB;
                end else if (tmo_last) begin
                    word_d[28] = 1'b1;
                    if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
                    state_d    = S_WB;
                end
            end
            S_WB: begin
                ptr_d   = ptr_next;
                state_d = sched_en ? S_RD : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        enb_d       = 1'b0;
        web_d       = 1'b0;
        addrb_d     = '0;
        dib_d       = '0;
        spi_req_d   = 1'b0;
        spi_rnw_d   = 1'b0;
        spi_addr_d  = '0;
        spi_wdata_d = '0;
        busy_d      = (state_d != S_IDLE);

        unique case (state_d)
            S_RD: begin
                enb_d   = 1'b1;
                addrb_d = ptr_d;
            end
            S_REQ, S_WAIT: begin
                spi_req_d   = 1'b1;
                spi_rnw_d   = word_d[29];
                spi_addr_d  = word_d[14:8];
                spi_wdata_d = word_d[7:0];
            end
            S_WB: begin
                enb_d   = 1'b1;
                web_d   = 1'b1;
                addrb_d = ptr_d;
                dib_d   = {2'b11, word_d};
            end
            default: begin
            end
        endcase
    end

    assign bus.enb       = enb_q;
    assign bus.web       = web_q;
    assign bus.addrb     = addrb_q;
    assign bus.dib       = dib_q;
    assign bus.spi_req   = spi_req_q;
    assign bus.spi_rnw   = spi_rnw_q;
    assign bus.spi_addr  = spi_addr_q;
    assign bus.spi_wdata = spi_wdata_q;
    assign sched_busy    = busy_q;
    assign msg_cnt       = msg_cnt_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_spi_buf_sched.sv
// Bench for spi_buf_sched: port-B buffer model, SPI responder and a write-back scoreboard.
module tb_spi_buf_sched;

    localparam int DEPTH   = 256;
    localparam int AW      = 8;
    localparam int TIMEOUT = 20;
    localparam int TW      = 5;

    typedef struct {
        int          slot;
        logic [31:0] word;
        int          delay;
        bit          withhold;
        logic [7:0]  rdata;
        logic        exp_rnw;
        logic [6:0]  exp_addr;
        logic [7:0]  exp_wdata;
        logic [31:0] exp_dib;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sched_en;
    logic        sched_busy;
    logic [15:0] msg_cnt;
    logic [7:0]  err_cnt;

    spi_buf_sched_if #(.AW(AW)) bus();

    spi_buf_sched #(
        .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT), .TW(TW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sched_en(sched_en),
        .bus(bus),
        .sched_busy(sched_busy),
        .msg_cnt(msg_cnt),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Buffer port B: samples on the falling edge, read data valid by the next rising edge.
    logic [31:0]   mem [DEPTH];
    logic          post_req  = 1'b0;
    logic          post_clr  = 1'b0;
    logic          sat_mode  = 1'b0;
    logic [AW-1:0] post_addr = '0;
    logic [31:0]   post_data = '0;

    always @(negedge clk) begin
        if (post_clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (post_req) begin
            mem[post_addr] <= post_data;
        end
        if (bus.enb) begin
            if (bus.web) mem[bus.addrb] <= sat_mode ? {4'b0100, bus.dib[27:0]} : bus.dib;
            else         bus.dob <= mem[bus.addrb];
        end
    end

    vec_t        sb_q[$];
    logic [15:0] exp_msg = '0;
    logic [7:0]  exp_err = '0;
    int          sat_wb  = 0;
    vec_t        mon_t;

    // Write-back monitor: pops the scoreboard and tracks the expected counters.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_msg = '0;
                exp_err = '0;
            end else if (bus.enb && bus.web) begin
                if (sat_mode) begin
                    sat_wb++;
                    if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                end else if (sb_q.size() == 0) begin
                    check("wb_unexpected", 32'(bus.web), 32'd0);
                end else begin
                    mon_t = sb_q.pop_front();
                    check("wb_addr", 32'(bus.addrb), 32'(mon_t.slot));
                    check("wb_dib", bus.dib, mon_t.exp_dib);
                    if (mon_t.withhold) begin
                        if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
                    end else begin
                        exp_msg = exp_msg + 16'd1;
                    end
                end
                check("msg_cnt", 32'(msg_cnt), 32'(exp_msg));
                check("err_cnt", 32'(err_cnt), 32'(exp_err));
            end
        end
    end

    int stray_n    = 0;
    int stray_done = 0;
    bit resp_hold  = 1'b0;
    vec_t r;
    int   hi;

    // SPI responder: checks each request against the scoreboard head and answers it.
    initial begin
        bus.spi_done  = 1'b0;
        bus.spi_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (stray_done < stray_n && !bus.spi_req) begin
                bus.spi_done  = 1'b1;
                bus.spi_rdata = 8'hFF;
                @(negedge clk);
                bus.spi_done  = 1'b0;
                bus.spi_rdata = 8'h00;
                stray_done++;
            end else if (bus.spi_req && rst_n) begin
                hi = 1;
                if (sat_mode) begin
                    while (bus.spi_req && hi < TIMEOUT + 10) begin @(negedge clk); hi++; end
                end else if (sb_q.size() == 0) begin
                    check("req_unexpected", 32'(bus.spi_req), 32'd0);
                    while (bus.spi_req && hi < TIMEOUT + 10) begin @(negedge clk); hi++; end
                end else begin
                    r = sb_q[0];
                    check("req_rnw", 32'(bus.spi_rnw), 32'(r.exp_rnw));
                    check("req_addr", 32'(bus.spi_addr), 32'(r.exp_addr));
                    check("req_wdata", 32'(bus.spi_wdata), 32'(r.exp_wdata));
                    if (r.withhold || resp_hold) begin
                        while (bus.spi_req && hi < TIMEOUT + 10) begin
                            @(negedge clk);
                            if (bus.spi_req) hi++;
                        end
                        if (r.withhold)
                            check("req_timeout_len", 32'(hi >= TIMEOUT && hi <= TIMEOUT + 1), 32'd1);
                    end else begin
                        repeat (r.delay + 1) begin
                            @(negedge clk);
                            check("req_held", 32'({bus.spi_req, bus.spi_rnw, bus.spi_addr, bus.spi_wdata}),
                                  32'({1'b1, r.exp_rnw, r.exp_addr, r.exp_wdata}));
                        end
                        bus.spi_done  = 1'b1;
                        bus.spi_rdata = r.rdata;
                        @(negedge clk);
                        bus.spi_done  = 1'b0;
                        bus.spi_rdata = 8'h00;
                        check("req_drop", 32'(bus.spi_req), 32'd0);
                    end
                end
            end
        end
    end

    task automatic post(input int slot, input logic [31:0] w);
        post_addr = slot[AW-1:0];
        post_data = w;
        post_req  = 1'b1;
        @(negedge clk);
        #1 post_req = 1'b0;
    endtask

    task automatic clear_mem();
        post_clr = 1'b1;
        @(negedge clk);
        #1 post_clr = 1'b0;
    endtask

    task automatic wait_sb_empty(input string name, input int budget);
        int n = 0;
        while (sb_q.size() != 0 && n < budget) begin @(negedge clk); n++; end
        check(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (sched_busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
        check(name, 32'(sched_busy), 32'd0);
    endtask

    task automatic wait_req(input string name, input int budget);
        int n = 0;
        while (bus.spi_req !== 1'b1 && n < budget) begin @(negedge clk); n++; end
        check(name, 32'(bus.spi_req), 32'd1);
    endtask

    initial begin
        vec_t vecs[6];
        int   bad, reads, wr, rq, n;

        vecs[0] = '{5,   32'h4000_1234, 2,           1'b0, 8'h00, 1'b0, 7'h12, 8'h34, 32'hC000_1234};
        vecs[1] = '{9,   32'h6000_2A00, 4,           1'b0, 8'hA5, 1'b1, 7'h2A, 8'h00, 32'hE000_2AA5};
        vecs[2] = '{0,   32'h4ABC_7F55, 0,           1'b0, 8'h00, 1'b0, 7'h7F, 8'h55, 32'hCABC_7F55};
        vecs[3] = '{255, 32'h7FFF_8001, 7,           1'b0, 8'h3C, 1'b1, 7'h00, 8'h01, 32'hEFFF_803C};
        vecs[4] = '{128, 32'h4000_00FF, TIMEOUT - 1, 1'b0, 8'h00, 1'b0, 7'h00, 8'hFF, 32'hC000_00FF};
        vecs[5] = '{3,   32'h4000_5A5A, 0,           1'b1, 8'h00, 1'b0, 7'h5A, 8'h5A, 32'hD000_5A5A};

        rst_n    = 1'b1;
        sched_en = 1'b0;
        #2 rst_n = 1'b0;
        clear_mem();
        @(negedge clk);
        check("rst_enb", 32'(bus.enb), 32'd0);
        check("rst_web", 32'(bus.web), 32'd0);
        check("rst_addrb", 32'(bus.addrb), 32'd0);
        check("rst_dib", bus.dib, 32'd0);
        check("rst_spi_req", 32'(bus.spi_req), 32'd0);
        check("rst_spi_rnw", 32'(bus.spi_rnw), 32'd0);
        check("rst_spi_addr", 32'(bus.spi_addr), 32'd0);
        check("rst_spi_wdata", 32'(bus.spi_wdata), 32'd0);
        check("rst_busy", 32'(sched_busy), 32'd0);
        check("rst_msg_cnt", 32'(msg_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_enb", 32'(bus.enb), 32'd0);
        check("idle_busy", 32'(sched_busy), 32'd0);

        // Empty buffer sweep, with stray spi_done pulses that must be ignored.
        sched_en = 1'b1;
        stray_n  = 3;
        n = 0;
        while (bus.enb !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("sweep_start", 32'(bus.enb), 32'd1);
        bad = 0; reads = 0; wr = 0; rq = 0;
        for (int i = 0; i < 516; i++) begin
            if (bus.enb !== ((i % 2) == 0)) bad++;
            if (bus.enb === 1'b1) begin
                reads++;
                if (bus.addrb !== AW'(i / 2)) bad++;
            end
            if (bus.web === 1'b1) wr++;
            if (bus.spi_req === 1'b1) rq++;
            @(negedge clk);
        end
        check("sweep_order", 32'(bad), 32'd0);
        check("sweep_reads", 32'(reads), 32'd258);
        check("sweep_web", 32'(wr), 32'd0);
        check("sweep_req", 32'(rq), 32'd0);
        check("sweep_busy", 32'(sched_busy), 32'd1);
        check("stray_msg_cnt", 32'(msg_cnt), 32'd0);
        check("stray_sent", 32'(stray_done), 32'd3);

        for (int i = 0; i < 6; i++) begin
            sb_q.push_back(vecs[i]);
            post(vecs[i].slot, vecs[i].word);
            wait_sb_empty($sformatf("vec%0d_done", i), 1200);
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_mem", i), mem[vecs[i].slot], vecs[i].exp_dib);
        end
        check("vec_msg_cnt", 32'(msg_cnt), 32'd5);
        check("vec_err_cnt", 32'(err_cnt), 32'd1);

        // Collected-pending, ready-only and error-only slots are never written.
        post(10, 32'hC000_0010);
        post(11, 32'h8000_0011);
        post(12, 32'h1000_0012);
        repeat (600) @(negedge clk);
        check("skip_mem10", mem[10], 32'hC000_0010);
        check("skip_mem11", mem[11], 32'h8000_0011);
        check("skip_mem12", mem[12], 32'h1000_0012);
        check("skip_msg_cnt", 32'(msg_cnt), 32'd5);

        // Saturation: every slot pending, SPI never answers, each write-back reposts the slot.
        sched_en = 1'b0;
        wait_idle("sat_pre_idle", 100);
        sat_mode = 1'b1;
        for (int i = 0; i < DEPTH; i++) post(i, 32'h4000_0000 | 32'(i));
        sched_en = 1'b1;
        n = 0;
        while (sat_wb < 300 && n < 15000) begin @(negedge clk); n++; end
        check("sat_timeouts", 32'(sat_wb >= 300), 32'd1);
        sched_en = 1'b0;
        wait_idle("sat_post_idle", 100);
        check("sat_err_cnt", 32'(err_cnt), 32'hFF);
        check("sat_msg_cnt", 32'(msg_cnt), 32'd5);
        sat_mode = 1'b0;
        clear_mem();

        // Reset while waiting on slot 7: request drops at once, slot re-served after rescan.
        resp_hold = 1'b1;
        sb_q.push_back('{7, 32'h4000_0777, 3, 1'b0, 8'h00, 1'b0, 7'h07, 8'h77, 32'hC000_0777});
        post(7, 32'h4000_0777);
        sched_en = 1'b1;
        wait_req("rst_wait_req", 600);
        repeat (3) @(negedge clk);
        check("rst_req_held", 32'(bus.spi_req), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_req_async", 32'(bus.spi_req), 32'd0);
        check("rst_busy_async", 32'(sched_busy), 32'd0);
        check("rst_msg_clear", 32'(msg_cnt), 32'd0);
        check("rst_err_clear", 32'(err_cnt), 32'd0);
        resp_hold = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_slot_kept", mem[7], 32'h4000_0777);
        rst_n = 1'b1;
        wait_sb_empty("rst_reserve", 1200);
        repeat (2) @(negedge clk);
        check("rst_mem7", mem[7], 32'hC000_0777);
        check("rst_msg_cnt", 32'(msg_cnt), 32'd1);

        // sched_en dropped mid-message: finish slot 2, idle, then resume at slot 3.
        sched_en = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back('{2,   32'h4000_0222, 6, 1'b0, 8'h00, 1'b0, 7'h02, 8'h22, 32'hC000_0222});
        sb_q.push_back('{200, 32'h6000_7100, 1, 1'b0, 8'h99, 1'b1, 7'h71, 8'h00, 32'hE000_7199});
        post(2, 32'h4000_0222);
        post(200, 32'h6000_7100);
        sched_en = 1'b1;
        wait_req("en_wait_req", 50);
        @(negedge clk);
        sched_en = 1'b0;
        n = 0;
        while (sb_q.size() != 1 && n < 100) begin @(negedge clk); n++; end
        check("en_slot2_done", 32'(sb_q.size()), 32'd1);
        repeat (2) @(negedge clk);
        check("en_idle", 32'(sched_busy), 32'd0);
        rq = 0;
        repeat (20) begin
            if (bus.enb === 1'b1) rq++;
            @(negedge clk);
        end
        check("en_no_scan", 32'(rq), 32'd0);
        check("en_slot200_pending", mem[200], 32'h6000_7100);
        sched_en = 1'b1;
        n = 0;
        while (bus.enb !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        check("en_resume_ptr", 32'(bus.addrb), 32'd3);
        wait_sb_empty("en_slot200_done", 600);
        repeat (2) @(negedge clk);
        check("en_mem200", mem[200], 32'hE000_7199);
        check("en_msg_cnt", 32'(msg_cnt), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
